vga_sync: RTL and testbench

Raster timing generator for the 640x480 @ 60 Hz VGA path. It consumes the one-clock-wide 25 MHz pixel-enable tick produced from the 100 MHz system clock and advances horizontal and vertical counters once per tick. It drives `hsync`/`vsync` to the connector and provides pixel coordinates plus `video_on` to the Breakout renderer. All outputs are registered and mutually consistent in every clock cycle.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_sync.sv | 108 ++++++++++
 tb/tb_vga_sync.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480 @ 60 Hz raster.
// Used as parameter defaults by vga_sync. The renderer imports the same
// package for its visible-area bounds.
package vga_pkg;

  // Horizontal timing, in pixel ticks
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;

  // Vertical timing, in lines
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;  // 525

  // Width of pixel_x / pixel_y
  localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-at-N counter for one raster axis.
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset (count -> 0)
//   i_en         advance enable
//   o_count      registered count, 0..N-1
//   o_count_next value o_count takes on the next edge (for registered decode)
//   o_wrap       high when an enabled edge moves N-1 -> 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned N = H_TOTAL,
  parameter int unsigned W = COORD_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;
  logic         w_at_last;

  always_comb begin
    w_at_last    = (r_count == LAST);
    o_wrap       = i_en && w_at_last;
    w_count_next = r_count;
    // Reset is folded in so the next-state decode upstream sees reset values too
    if (i_reset) begin
      w_count_next = '0;
    end else if (i_en) begin
      w_count_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator. Advances the horizontal/vertical counters on
// each pixel-enable tick and produces registered sync, blanking and
// frame-start signals that always agree with the current coordinates.
// Ports:
//   clk          system clock (only clock)
//   reset        synchronous active-high reset
//   tick25Mhz    pixel enable
//   hsync/vsync  active-low sync pulses
//   video_on     high inside the visible area
//   pixel_x/y    current raster coordinates
//   frame_start  one-cycle pulse when the counters enter (0,0)
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick25Mhz,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_v_en;

  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  logic r_frame_start;

  assign w_v_en = tick25Mhz && w_h_wrap;

  vga_axis_counter #(
    .N (HTotal),
    .W (COORD_W)
  ) u_h_counter (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (tick25Mhz),
    .o_count      (w_x),
    .o_count_next (w_x_next),
    .o_wrap       (w_h_wrap)
  );

  vga_axis_counter #(
    .N (VTotal),
    .W (COORD_W)
  ) u_v_counter (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (w_v_en),
    .o_count      (w_y),
    .o_count_next (w_y_next),
    .o_wrap       (w_v_wrap)
  );

  // Decode from the next-state counts so the flops land on the same edge as
  // the counters; with no tick the next counts equal the current ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
      r_vsync       <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
      r_video_on    <= (w_x_next < H_VIS_END) && (w_y_next < V_VIS_END);
      // w_v_wrap already implies tick and horizontal wrap
      r_frame_start <= w_v_wrap;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;
  assign pixel_x     = w_x;
  assign pixel_y     = w_y;

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  // Full-size 640x480 instance plus a shrunken instance so vertical/frame
  // behaviour is reachable in a short run.
  localparam int unsigned S_HD = 20, S_HF = 4, S_HS = 8, S_HB = 4;  // 36 per line
  localparam int unsigned S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;  // 17 lines
  localparam int unsigned S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int unsigned S_FRAME = S_HT * (S_VD + S_VF + S_VS + S_VB);  // 612
  localparam int unsigned B_FRAME = 800 * 525;

  logic clk, reset, tick25Mhz;

  logic       hs_b, vs_b, vo_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, vo_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_sync u_dut (
    .clk (clk), .reset (reset), .tick25Mhz (tick25Mhz),
    .hsync (hs_b), .vsync (vs_b), .video_on (vo_b),
    .pixel_x (x_b), .pixel_y (y_b), .frame_start (fs_b)
  );

  vga_sync #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) u_small (
    .clk (clk), .reset (reset), .tick25Mhz (tick25Mhz),
    .hsync (hs_s), .vsync (vs_s), .video_on (vo_s),
    .pixel_x (x_s), .pixel_y (y_s), .frame_start (fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: ticks since reset; coordinates follow by division.
  int unsigned m_n = 0;
  logic        m_fs_b = 1'b0;
  logic        m_fs_s = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_n    <= 0;
      m_fs_b <= 1'b0;
      m_fs_s <= 1'b0;
    end else if (tick25Mhz) begin
      m_n    <= m_n + 1;
      m_fs_b <= ((m_n + 1) % B_FRAME) == 0;
      m_fs_s <= ((m_n + 1) % S_FRAME) == 0;
    end else begin
      m_fs_b <= 1'b0;
      m_fs_s <= 1'b0;
    end
  end

  function automatic logic [23:0] exp_one(int unsigned n, logic fs,
      int unsigned hd, int unsigned hf, int unsigned hs, int unsigned hb,
      int unsigned vd, int unsigned vf, int unsigned vs, int unsigned vb);
    int unsigned ht = hd + hf + hs + hb;
    int unsigned vt = vd + vf + vs + vb;
    int unsigned x = n % ht;
    int unsigned y = (n / ht) % vt;
    logic h = !((x >= hd + hf) && (x < hd + hf + hs));
    logic v = !((y >= vd + vf) && (y < vd + vf + vs));
    logic von = (x < hd) && (y < vd);
    return {h, v, von, fs, 10'(x), 10'(y)};
  endfunction

  function automatic logic [47:0] exp_all();
    return {exp_one(m_n, m_fs_b, 640, 16, 96, 48, 480, 10, 2, 33),
            exp_one(m_n, m_fs_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB)};
  endfunction

  wire [47:0] obs = {hs_b, vs_b, vo_b, fs_b, x_b, y_b, hs_s, vs_s, vo_s, fs_s, x_s, y_s};

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tb_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick25Mhz = (i == 1);
      tb_cycle();
      checks++;
      if ({hs_b, vs_b, vo_b, fs_b, x_b, y_b, hs_s, vs_s, vo_s, fs_s, x_s, y_s} !==
          {4'b1110, 20'd0, 4'b1110, 20'd0}) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got=%h exp=%h", i, obs,
                 {4'b1110, 20'd0, 4'b1110, 20'd0});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick25Mhz = (i == 3);
      tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
    tick25Mhz = 1'b0;
    checks++;
    if (x_b !== 10'd1 || x_s !== 10'd1) begin
      errors++;
      $display("FAIL first_tick_x got=%0d/%0d exp=1", x_b, x_s);
    end
  endtask

  // One full line plus a bit with randomized tick spacing.
  task automatic test_line();
    int unsigned hs_low = 0;
    for (int t = 0; t < 820; t++) begin
      int unsigned gap = $urandom_range(0, 3);
      tick25Mhz = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tb_cycle();
        checks++;
        if (obs !== exp_all()) begin
          errors++;
          $display("FAIL line_idle n=%0d got=%h exp=%h", m_n, obs, exp_all());
        end
      end
      tick25Mhz = 1'b1;
      tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL line_tick n=%0d got=%h exp=%h", m_n, obs, exp_all());
      end
      if (m_n <= 800 && !hs_b) hs_low++;
    end
    tick25Mhz = 1'b0;
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
  endtask

  task automatic test_stall();
    int unsigned guard = 0;
    tick25Mhz = 1'b0;
    while ((m_n % 800) != 300 && guard < 4000) begin
      tick25Mhz = ((guard % 4) == 3);
      tb_cycle();
      guard++;
    end
    tick25Mhz = 1'b0;
    checks++;
    if (x_b !== 10'd300) begin
      errors++;
      $display("FAIL stall_reach got=%0d exp=300", x_b);
    end
    for (int i = 0; i < 50; i++) begin
      tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
    tick25Mhz = 1'b1;
    tb_cycle();
    tick25Mhz = 1'b0;
    checks++;
    if (x_b !== 10'd301) begin
      errors++;
      $display("FAIL stall_resume got=%0d exp=301", x_b);
    end
  endtask

  // Tick held high from reset release; count sync widths and frame pulses.
  task automatic test_frame();
    int unsigned vs_low = 0, hs_low = 0, pulses = 0, first_pulse = 0;
    reset = 1'b1;
    tick25Mhz = 1'b1;
    tb_cycle();
    reset = 1'b0;
    for (int c = 1; c <= 900; c++) begin
      tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL frame_run c=%0d got=%h exp=%h", c, obs, exp_all());
      end
      if (!vs_s) vs_low++;
      if (!hs_b && c <= 800) hs_low++;
      if (fs_s) begin
        pulses++;
        if (first_pulse == 0) first_pulse = c;
      end
    end
    checks++;
    if (vs_low != S_VS * S_HT) begin
      errors++;
      $display("FAIL vsync_cycles got=%0d exp=%0d", vs_low, S_VS * S_HT);
    end
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_cycles got=%0d exp=96", hs_low);
    end
    checks++;
    if (pulses != 1 || first_pulse != S_FRAME) begin
      errors++;
      $display("FAIL frame_pulse got=%0d@%0d exp=1@%0d", pulses, first_pulse, S_FRAME);
    end
  endtask

  // Reset coincident with tick inside the sync regions.
  task automatic test_reset_mid();
    int unsigned targets[2] = '{498, 700};
    for (int k = 0; k < 2; k++) begin
      reset = 1'b1;
      tick25Mhz = 1'b1;
      tb_cycle();
      reset = 1'b0;
      for (int c = 0; c < 2000 && m_n < targets[k]; c++) tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL mid_position n=%0d got=%h exp=%h", m_n, obs, exp_all());
      end
      reset = 1'b1;
      tb_cycle();
      checks++;
      if (obs !== {4'b1110, 20'd0, 4'b1110, 20'd0}) begin
        errors++;
        $display("FAIL mid_reset k=%0d got=%h exp=%h", k, obs,
                 {4'b1110, 20'd0, 4'b1110, 20'd0});
      end
    end
    reset = 1'b0;
    tick25Mhz = 1'b0;
  endtask

  task automatic test_boundary();
    reset = 1'b1;
    tick25Mhz = 1'b1;
    tb_cycle();
    reset = 1'b0;
    for (int c = 0; c < 2000 && m_n < S_FRAME - 1; c++) tb_cycle();
    checks++;
    if (x_s !== 10'd35 || y_s !== 10'd16 || fs_s !== 1'b0) begin
      errors++;
      $display("FAIL boundary_pre got=(%0d,%0d,%b) exp=(35,16,0)", x_s, y_s, fs_s);
    end
    tb_cycle();
    checks++;
    if ({x_s, y_s, vo_s, fs_s, hs_s, vs_s} !== {20'd0, 4'b1111}) begin
      errors++;
      $display("FAIL boundary_wrap got=(%0d,%0d,%b,%b,%b,%b) exp=(0,0,1,1,1,1)",
               x_s, y_s, vo_s, fs_s, hs_s, vs_s);
    end
    tick25Mhz = 1'b0;
    tb_cycle();
    checks++;
    if (fs_s !== 1'b0 || x_s !== 10'd0) begin
      errors++;
      $display("FAIL boundary_one_cycle got=fs%b x%0d exp=fs0 x0", fs_s, x_s);
    end
    tick25Mhz = 1'b1;
    tb_cycle();
    checks++;
    if (fs_s !== 1'b0 || x_s !== 10'd1) begin
      errors++;
      $display("FAIL boundary_next got=fs%b x%0d exp=fs0 x1", fs_s, x_s);
    end
  endtask

  // Random tick and occasional reset, every cycle against the model.
  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      tick25Mhz = $urandom_range(0, 1) != 0;
      tb_cycle();
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_all());
      end
    end
    reset = 1'b0;
    tick25Mhz = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick25Mhz = 1'b0;
    test_reset();
    test_line();
    test_stall();
    test_frame();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
